// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two combinational read
// ports, one synchronous write port, an optional hardwired-zero register 0
// and a sequenced bulk-clear engine (IDLE/CLEAR).
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_param #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ok,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic                done_reg, done_next;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH-1:0]    wr_sel;
  logic [DEPTH-1:0]    clr_sel;

  // Writes are refused while the clear engine owns the array.
  assign wr_ok    = wr_en & ~clr_busy;
  assign clr_busy = (state_reg == CLEAR);
  assign clr_done = done_reg;

  // Per-register select lines for normal writes and for the clear sweep.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      if (ZERO_REG != 0 && gi == 0) begin : g_zero
        assign wr_sel[gi] = 1'b0;
      end else begin : g_norm
        assign wr_sel[gi] = wr_ok && (wr_addr == ADDR_W'(gi));
      end
      assign clr_sel[gi] = clr_busy && (cnt_reg == ADDR_W'(gi));
    end
  endgenerate

  // Register array: reset to zero, clear sweep, then ordinary write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem[i] <= '0;
      end else if (clr_sel[i]) begin
        mem[i] <= '0;
      end else if (wr_sel[i]) begin
        mem[i] <= wr_data;
      end
    end
  end

  // Clear FSM state, sweep counter and done pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // Clear FSM next-state: sweep every address once, pulse done on the way out.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read mux: stored value, optional forwarding of the in-flight write,
  // and the hardwired zero for register 0 taking final precedence.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = mem[addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (addr == wr_addr)) begin
      val = wr_data;
    end
`endif
    if (ZERO_REG != 0 && addr == '0) begin
      val = '0;
    end
    return val;
  endfunction

  assign rd_data1 = read_port(rd_addr1);
  assign rd_data2 = read_port(rd_addr2);

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default parameters). Expected read
// data comes from a bench-side register model and is queued on a scoreboard
// when stimulus is driven, then popped and compared when the DUT answers.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr;
  logic [15:0] rd_data1, rd_data2, wr_data;
  logic        wr_en, wr_ok, clr_req, clr_busy, clr_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic [15:0] model [16];

  regfile_param dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ok    (wr_ok),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [15:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {16'h0, obs}, {16'h0, e.exp});
    end
  endtask

  // One read transaction on both ports, mid-cycle with no write pending.
  task automatic read_pair(input logic [3:0] a1, input logic [3:0] a2);
    @(negedge clk);
    rd_addr1 = a1;
    rd_addr2 = a2;
    sb_push($sformatf("rd1[%0d]", a1), model[a1]);
    sb_push($sformatf("rd2[%0d]", a2), model[a2]);
    #1;
    sb_pop(rd_data1);
    sb_pop(rd_data2);
  endtask

  // One accepted write; returns 1 time unit after the committing edge.
  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    #1;
    check($sformatf("wr_ok[%0d]", a), {31'h0, wr_ok}, 32'd1);
    @(posedge clk);
    if (a != 4'd0) model[a] = d;
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
  endtask

  task automatic fill_regs(input logic [15:0] base);
    for (int i = 1; i < 16; i++) begin
      do_write(4'(i), base + 16'(i * 16'h0111));
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic [15:0] old7;
    logic [15:0] old10;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; clr_req = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_busy", {31'h0, clr_busy}, 32'd0);
    check("rst_done", {31'h0, clr_done}, 32'd0);
    wr_en = 1'b1;
    #1;
    check("rst_wr_ok", {31'h0, wr_ok}, 32'd1);
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) read_pair(4'(i), 4'(15 - i));

    // Basic write/read and hardwired zero.
    do_write(4'd5, 16'hBEEF);
    read_pair(4'd5, 4'd5);
    do_write(4'd0, 16'h1234);
    read_pair(4'd0, 4'd5);

    // Same-cycle write/read of R3.
    do_write(4'd3, 16'h0001);
    @(negedge clk);
    rd_addr1 = 4'd3;
    wr_en    = 1'b1;
    wr_addr  = 4'd3;
    wr_data  = 16'hA5A5;
`ifdef REGFILE_BYPASS_EN
    sb_push("bypass_r3", 16'hA5A5);
`else
    sb_push("nobypass_r3", 16'h0001);
`endif
    #1;
    sb_pop(rd_data1);
    @(posedge clk);
    model[3] = 16'hA5A5;
    #1;
    wr_en = 1'b0;
    read_pair(4'd3, 4'd3);

    // Full clear with a dropped write to R7.
    fill_regs(16'h1000);
    old7 = model[7];
    pulse_clear();
    n = 0;
    while (clr_busy && n < 40) begin
      if (n == 2) begin
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hFFFF;
        #1;
        check("clr_wr_ok", {31'h0, wr_ok}, 32'd0);
      end
      if (n == 3) begin
        rd_addr1 = 4'd7;
        sb_push("clr_r7_kept", old7);
        #1;
        sb_pop(rd_data1);
      end
      if (clr_done) check("done_in_busy", {31'h0, clr_done}, 32'd0);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      n++;
    end
    check("clr_busy_len", 32'(n), 32'd16);
    check("clr_done_hi", {31'h0, clr_done}, 32'd1);
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    @(posedge clk);
    #1;
    check("clr_done_lo", {31'h0, clr_done}, 32'd0);
    for (int i = 0; i < 16; i++) read_pair(4'(i), 4'(15 - i));

    // Partial clear observed mid-sweep, then aborted by reset.
    fill_regs(16'h2000);
    old10 = model[10];
    pulse_clear();
    repeat (6) @(posedge clk);
    #1;
    rd_addr1 = 4'd10;
    rd_addr2 = 4'd5;
    sb_push("mid_r10_old", old10);
    sb_push("mid_r5_zero", 16'h0000);
    #1;
    sb_pop(rd_data1);
    sb_pop(rd_data2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    check("abort_busy", {31'h0, clr_busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (clr_done) pulses++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    read_pair(4'd10, 4'd15);

    // Back-to-back clears with clr_req held high.
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (clr_busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_len", 32'(n), 32'd16);
    check("b2b_done", {31'h0, clr_done}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_rebusy", {31'h0, clr_busy}, 32'd1);
    check("b2b_done_lo", {31'h0, clr_done}, 32'd0);
    clr_req = 1'b0;
    n = 0;
    while (!clr_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_second_len", 32'(n), 32'd16);
    read_pair(4'd1, 4'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
